set_assoc_cache_controller: RTL

//  Parametrised N-way set-associative read cache between the ARM MEM stage and the SRAM controller.

---
 rtl/cache_pkg.sv | 41 ++++
 rtl/cache_plru.sv | 28 ++
 rtl/set_assoc_cache_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative read cache: FSM encoding, address-field
// widths and the tree pseudo-LRU helpers used by cache_plru.
package cache_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_FLUSH} state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Byte offset inside a line: word select plus the two ignored byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction

  // Tree layout: bit0 = root (1 -> victim on the upper pair), bit1 = ways 0/1, bit2 = ways 2/3.
  // With 2 ways only bit0 is meaningful and names the victim directly.
  function automatic logic [2:0] plru_touch(input int ways, input logic [2:0] st,
                                            input logic [1:0] way);
    logic [2:0] n;
    n = st;
    if (ways == 2) begin
      n[0] = ~way[0];
    end else begin
      n[0] = ~way[1];
      if (way[1]) n[2] = ~way[0];
      else        n[1] = ~way[0];
    end
    return n;
  endfunction

  function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] st);
    if (ways == 2) return {1'b0, st[0]};
    return st[0] ? {1'b1, st[2]} : {1'b0, st[1]};
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set pseudo-LRU replacement state: one touch port, one victim lookup, bulk clear.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    touch,
  input  logic [$clog2(SETS)-1:0] touch_set,
  input  logic [1:0]              touch_way,
  input  logic [$clog2(SETS)-1:0] vic_set,
  output logic [1:0]              vic_way
);

  logic [SETS-1:0][2:0] st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       st <= '0;
    else if (clear) st <= '0;
    else if (touch) st[touch_set] <= plru_touch(WAYS, st[touch_set], touch_way);
  end

  assign vic_way = plru_victim(WAYS, st[vic_set]);

endmodule

// File: rtl/set_assoc_cache_controller.sv
// N-way write-through, no-write-allocate read cache between the MEM stage and the SRAM
// controller. Read hits complete combinationally; misses fill a whole line from SRAM.
module set_assoc_cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdEnIn,
  input  logic                     wrEnIn,
  input  logic [31:0]              adrIn,
  input  logic [31:0]              wDataIn,
  input  logic                     flushIn,
  output logic [31:0]              rDataOut,
  output logic                     readyOut,
  output logic                     sramRdEnOut,
  output logic                     sramWrEnOut,
  output logic [31:0]              sramAdrOut,
  output logic [31:0]              sramWDataOut,
  input  logic                     sramReadyIn,
  input  logic [32*LINE_WORDS-1:0] sramReadDataIn,
  output logic [CNT_W-1:0]         hitCntOut,
  output logic [CNT_W-1:0]         missCntOut
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WO_W   = OFF_W - 2;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = 32 * LINE_WORDS;

  state_e                  state;
  logic [31:0]             lat_adr, lat_data;
  logic [TAG_W-1:0]        tags  [WAYS][SETS];
  logic [LINE_W-1:0]       lines [WAYS][SETS];
  logic [WAYS-1:0][SETS-1:0] valid;
  logic [CNT_W-1:0]        hit_cnt, miss_cnt;

  logic [IDX_W-1:0] idx, lat_idx;
  logic [TAG_W-1:0] tag, lat_tag;
  logic [WO_W-1:0]  off, lat_off;

  assign idx     = adrIn[OFF_W +: IDX_W];
  assign tag     = adrIn[OFF_W+IDX_W +: TAG_W];
  assign off     = adrIn[2 +: WO_W];
  assign lat_idx = lat_adr[OFF_W +: IDX_W];
  assign lat_tag = lat_adr[OFF_W+IDX_W +: TAG_W];
  assign lat_off = lat_adr[2 +: WO_W];

  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way, vic;
  logic [1:0]       plru_way;
  logic [31:0]      hit_word, fill_word;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid[w][idx] && (tags[w][idx] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end
  assign hit = |hit_vec;

  // Lowest invalid way wins; the pseudo-LRU pick only matters once the set is full.
  always_comb begin
    vic = plru_way[WAY_W-1:0];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w][lat_idx]) vic = WAY_W'(w);
  end

  assign hit_word  = lines[hit_way][idx][{off, 5'b0} +: 32];
  assign fill_word = sramReadDataIn[{lat_off, 5'b0} +: 32];

  logic rd_req, wr_req, rd_hit, wr_hit, fill_done, wr_done;
  assign wr_req    = wrEnIn & ~flushIn;
  assign rd_req    = rdEnIn & ~wrEnIn & ~flushIn;
  assign rd_hit    = (state == S_IDLE) && rd_req && hit;
  assign wr_hit    = (state == S_IDLE) && wr_req && hit;
  assign fill_done = (state == S_FILL) && sramReadyIn;
  assign wr_done   = (state == S_WRITE) && sramReadyIn;

  assign readyOut     = rd_hit | fill_done | wr_done;
  assign rDataOut     = rd_hit ? hit_word : (fill_done ? fill_word : 32'h0);
  assign sramRdEnOut  = (state == S_FILL);
  assign sramWrEnOut  = (state == S_WRITE);
  assign sramAdrOut   = (state == S_FILL)  ? {lat_adr[31:OFF_W], {OFF_W{1'b0}}} :
                        (state == S_WRITE) ? lat_adr : 32'h0;
  assign sramWDataOut = (state == S_WRITE) ? lat_data : 32'h0;
  assign hitCntOut    = hit_cnt;
  assign missCntOut   = miss_cnt;

  cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == S_FLUSH),
    .touch     (rd_hit | wr_hit | fill_done),
    .touch_set (fill_done ? lat_idx : idx),
    .touch_way (fill_done ? 2'(vic) : 2'(hit_way)),
    .vic_set   (lat_idx),
    .vic_way   (plru_way)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      lat_adr  <= '0;
      lat_data <= '0;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flushIn) begin
            state <= S_FLUSH;
          end else if (wrEnIn) begin
            lat_adr  <= {adrIn[31:2], 2'b00};
            lat_data <= wDataIn;
            state    <= S_WRITE;
          end else if (rdEnIn && !hit) begin
            lat_adr <= {adrIn[31:2], 2'b00};
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            state   <= S_FILL;
          end else if (rdEnIn) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end
        end
        S_FILL: if (sramReadyIn) begin
          valid[vic][lat_idx] <= 1'b1;
          state               <= S_IDLE;
        end
        S_WRITE: if (sramReadyIn) state <= S_IDLE;
        S_FLUSH: begin
          valid <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tags[vic][lat_idx]  <= lat_tag;
      lines[vic][lat_idx] <= sramReadDataIn;
    end else if (wr_hit) begin
      lines[hit_way][idx][{off, 5'b0} +: 32] <= wDataIn;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{adrIn[1:0], plru_way};

  always_ff @(posedge clk)
    if (rst && state == S_IDLE) assert ($onehot0(hit_vec));

endmodule
